fib_bcd_converter: RTL and testbench

Sequential binary-to-BCD converter placed directly downstream of the `fibonacci` core. It captures the 121-bit `ans` result when the core raises `done` and converts it to packed decimal digits with the shift-add-3 (double-dabble) algorithm, one bit per clock. It also reports the count of significant decimal digits. Display and report logic use these outputs.

---
 rtl/fib_pkg.sv | 32 +++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/fib_bcd_converter.sv | 148 ++++++++++++++
 tb/tb_fib_bcd_converter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci result path.
// Holds the converter geometry (binary width, decimal digit count, packed BCD
// width), the converter state encoding, the bit counter width, and the
// per-digit add-3 correction used by the double-dabble datapath.
package fib_pkg;

  localparam int BIN_W  = 121;
  localparam int DIGITS = 37;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = 7;
  localparam int ND_W   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Pre-shift correction. A digit of 5..9 would become 10..18 after doubling,
  // so 3 is added first to make the doubled value carry into the next digit.
  function automatic logic [3:0] adj_digit(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational add-3 cell for one BCD digit.
// Ports:
//   digit_i  4-bit working digit
//   digit_o  digit_i + 3 when digit_i >= 5, otherwise digit_i
// Digits stay in 0..9 throughout, so the result always fits in 4 bits.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);
  import fib_pkg::*;

  assign digit_o = adj_digit(digit_i);

endmodule

// File: rtl/fib_bcd_converter.sv
// Sequential binary-to-BCD converter for the Fibonacci core result.
// Captures `bin` when `start` is seen in IDLE or DONE, then runs one
// shift-add-3 step per clock for BIN_W clocks, spends one clock copying the
// result and counting significant digits, and parks in DONE.
// Ports:
//   clk      clock, rising edge
//   reset    asynchronous active-low reset
//   start    conversion request (honoured only in IDLE or DONE)
//   bin      binary value, sampled with start
//   busy     high while shifting and counting
//   done     high in DONE until the next accepted start
//   bcd      packed BCD result, digit i at [4i+3:4i]
//   ndigits  number of significant decimal digits (1 for zero)
module fib_bcd_converter #(
  parameter int BIN_W  = fib_pkg::BIN_W,
  parameter int DIGITS = fib_pkg::DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [5:0]            ndigits
);
  localparam int BCD_W = 4 * DIGITS;

  import fib_pkg::state_e;
  import fib_pkg::IDLE;
  import fib_pkg::SHIFT;
  import fib_pkg::COUNT;
  import fib_pkg::DONE;
  import fib_pkg::CNT_W;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   wbcd_q, wbcd_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [5:0]         ndig_q, ndig_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   wbcd_adj_s;
  logic [5:0]         nd_s;
  // The top digit never reaches 8 after correction, so its MSB is always
  // shifted out as zero and carries no information.
  logic               unused_top_s;

  assign unused_top_s = wbcd_adj_s[BCD_W-1];

  // Per-digit add-3 correction applied to the working register before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (wbcd_q[4*g +: 4]),
      .digit_o (wbcd_adj_s[4*g +: 4])
    );
  end

  // Priority encode: highest non-zero digit index plus one; zero reports one digit.
  always_comb begin
    nd_s = 6'd1;
    for (int i = 0; i < DIGITS; i++) begin
      nd_s = (wbcd_q[4*i +: 4] != 4'd0) ? 6'(i + 1) : nd_s;
    end
  end

  // Next-state and datapath update for the conversion FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    wbcd_d  = wbcd_q;
    bcd_d   = bcd_q;
    ndig_d  = ndig_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          bin_d   = bin;
          wbcd_d  = '0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end else begin
          state_d = state_q;
        end
      end

      SHIFT: begin
        // {BCD, binary} shifts left as one long register.
        wbcd_d = {wbcd_adj_s[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d  = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = COUNT;
        end else begin
          state_d = SHIFT;
        end
      end

      COUNT: begin
        bcd_d   = wbcd_q;
        ndig_d  = nd_s;
        state_d = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d == SHIFT) || (state_d == COUNT);
    done_d = (state_d == DONE);
  end

  // State, working and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      wbcd_q  <= '0;
      bcd_q   <= '0;
      ndig_q  <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      wbcd_q  <= wbcd_d;
      bcd_q   <= bcd_d;
      ndig_q  <= ndig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd     = bcd_q;
  assign ndigits = ndig_q;

endmodule

// File: tb/tb_fib_bcd_converter.sv
module tb_fib_bcd_converter;

  localparam int BW = 121;
  localparam int DW = 148;
  localparam int LAT = 122;

  logic          clk;
  logic          reset;
  logic          start;
  logic [BW-1:0] bin;
  logic          busy;
  logic          done;
  logic [DW-1:0] bcd;
  logic [5:0]    ndigits;

  int checks;
  int failures;

  fib_bcd_converter dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .ndigits (ndigits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division by ten.
  function automatic logic [DW-1:0] ref_bcd(input logic [BW-1:0] v);
    logic [BW-1:0] t;
    logic [DW-1:0] r;
    t = v;
    r = '0;
    for (int i = 0; i < 37; i++) begin
      r[4*i +: 4] = 4'(t % 121'd10);
      t = t / 121'd10;
    end
    return r;
  endfunction

  function automatic int ref_nd(input logic [BW-1:0] v);
    logic [BW-1:0] t;
    int n;
    t = v;
    n = 0;
    while (t != '0) begin
      n++;
      t = t / 121'd10;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

  function automatic logic [BW-1:0] rand_val();
    logic [BW-1:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    v = v >> $urandom_range(0, BW - 1);
    return v;
  endfunction

  // Starts one conversion, optionally pulses start again at cycle pulse_at,
  // and counts edges until done (bounded).
  task automatic run_conv(input logic [BW-1:0] v, input int pulse_at,
                          output int lat, output int busy_n);
    @(negedge clk);
    bin = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin = rand_val();
    busy_n = busy ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      if (k == pulse_at) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (bcd !== '0) begin failures++; $display("FAIL reset_bcd got=%h exp=0", bcd); end
    checks++; if (ndigits !== 6'd0) begin failures++; $display("FAIL reset_nd got=%0d exp=0", ndigits); end
  endtask

  task automatic test_zero();
    int lat, bn;
    run_conv('0, 0, lat, bn);
    checks++; if (lat != LAT) begin failures++; $display("FAIL zero_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (bn != LAT) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=%0d", bn, LAT); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_low got=%b exp=0", busy); end
    checks++; if (bcd !== '0) begin failures++; $display("FAIL zero_bcd got=%h exp=0", bcd); end
    checks++; if (ndigits !== 6'd1) begin failures++; $display("FAIL zero_nd got=%0d exp=1", ndigits); end
  endtask

  task automatic test_fib30();
    int lat, bn;
    logic [DW-1:0] exp_v;
    exp_v = 148'h832040;
    run_conv(121'd832040, 0, lat, bn);
    checks++; if (lat != LAT) begin failures++; $display("FAIL fib30_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (bcd !== exp_v) begin failures++; $display("FAIL fib30_bcd got=%h exp=%h", bcd, exp_v); end
    checks++; if (ndigits !== 6'd6) begin failures++; $display("FAIL fib30_nd got=%0d exp=6", ndigits); end
  endtask

  task automatic test_max();
    int lat, bn;
    logic [DW-1:0] exp_v;
    logic [BW-1:0] v;
    exp_v = 148'h2658455991569831745807614120560689151;
    v = '1;
    run_conv(v, 0, lat, bn);
    checks++; if (lat != LAT) begin failures++; $display("FAIL max_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (bcd !== exp_v) begin failures++; $display("FAIL max_bcd got=%h exp=%h", bcd, exp_v); end
    checks++; if (ndigits !== 6'd37) begin failures++; $display("FAIL max_nd got=%0d exp=37", ndigits); end
  endtask

  task automatic test_start_ignored();
    int lat, bn;
    logic [DW-1:0] exp_v;
    exp_v = 148'h12345;
    run_conv(121'd12345, 50, lat, bn);
    checks++; if (lat != LAT) begin failures++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (bcd !== exp_v) begin failures++; $display("FAIL ignore_bcd got=%h exp=%h", bcd, exp_v); end
    checks++; if (ndigits !== 6'd5) begin failures++; $display("FAIL ignore_nd got=%0d exp=5", ndigits); end
    // After done, nothing should restart by itself.
    repeat (5) @(posedge clk);
    #1;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ignore_no_restart got=%b%b exp=10", done, busy); end
  endtask

  task automatic test_reset_mid();
    int lat, bn;
    logic [DW-1:0] exp_v;
    exp_v = 148'h99;
    @(negedge clk);
    bin = 121'd777777;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bcd !== '0) begin failures++; $display("FAIL rstmid_bcd got=%h exp=0", bcd); end
    checks++; if (ndigits !== 6'd0) begin failures++; $display("FAIL rstmid_nd got=%0d exp=0", ndigits); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=%b%b exp=00", done, busy); end
    @(negedge clk);
    reset = 1'b1;
    repeat (130) @(posedge clk);
    #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_no_resume got=%b%b exp=00", done, busy); end
    run_conv(121'd99, 0, lat, bn);
    checks++; if (lat != LAT) begin failures++; $display("FAIL rstmid_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (bcd !== exp_v) begin failures++; $display("FAIL rstmid_bcd99 got=%h exp=%h", bcd, exp_v); end
    checks++; if (ndigits !== 6'd2) begin failures++; $display("FAIL rstmid_nd99 got=%0d exp=2", ndigits); end
  endtask

  task automatic test_random();
    int lat, bn;
    logic [BW-1:0] v;
    for (int n = 0; n < 12; n++) begin
      v = rand_val();
      run_conv(v, $urandom_range(1, 121), lat, bn);
      checks++; if (lat != LAT) begin failures++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", n, lat, LAT); end
      checks++; if (bcd !== ref_bcd(v)) begin failures++; $display("FAIL rand_bcd[%0d] got=%h exp=%h", n, bcd, ref_bcd(v)); end
      checks++; if (int'(ndigits) != ref_nd(v)) begin failures++; $display("FAIL rand_nd[%0d] got=%0d exp=%0d", n, ndigits, ref_nd(v)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] a, b;
    int lat;
    a = rand_val();
    b = rand_val();
    // Start held high through the whole first conversion.
    @(negedge clk);
    bin = a;
    start = 1'b1;
    @(posedge clk);
    #1;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat != LAT) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (bcd !== ref_bcd(a)) begin failures++; $display("FAIL b2b_first_bcd got=%h exp=%h", bcd, ref_bcd(a)); end
    bin = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_restart got=%b%b exp=01", done, busy); end
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      if (k == 60) begin
        checks++; if (bcd !== ref_bcd(a)) begin failures++; $display("FAIL b2b_hold_bcd got=%h exp=%h", bcd, ref_bcd(a)); end
      end
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat != LAT) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (bcd !== ref_bcd(b)) begin failures++; $display("FAIL b2b_second_bcd got=%h exp=%h", bcd, ref_bcd(b)); end
  endtask

  task automatic test_fib_chain();
    logic [BW-1:0] fa, fb, ft;
    int lat, bn;
    fa = '0;
    fb = 121'd1;
    for (int n = 0; n <= 30; n++) begin
      run_conv(fa, 0, lat, bn);
      checks++; if (lat != LAT || bcd !== ref_bcd(fa) || int'(ndigits) != ref_nd(fa)) begin
        failures++;
        $display("FAIL fib_chain[%0d] got=%h/%0d/%0d exp=%h/%0d/%0d", n, bcd, ndigits, lat, ref_bcd(fa), ref_nd(fa), LAT);
      end
      ft = fa + fb;
      fa = fb;
      fb = ft;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    start = 1'b0;
    bin = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_zero();
    test_fib30();
    test_max();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_fib_chain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
